// File: rtl/debounce_edge_events.sv
// rtl/debounce_edge_events.sv - multi-channel debouncer with edge pulses and a queued edge-event stream
// Each channel: 2-flop sync, stable-count debounce, edge qualify, pulse stretch; events drain lowest channel first.
module debounce_edge_events #(
  parameter int    WIDTH         = 4,
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter string POLARITY      = "LOW",
  parameter int    PULSE_EXT     = 6,
  localparam int   CH_W          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [2*WIDTH-1:0]   edge_mode,
  input  logic [WIDTH-1:0]     retrigger,
  input  logic [WIDTH-1:0]     ovr_clear,
  input  logic                 evt_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic [WIDTH-1:0]     pulse_out,
  output logic [WIDTH-1:0]     busy,
  output logic                 evt_valid,
  output logic [CH_W-1:0]      evt_ch,
  output logic                 evt_rise,
  output logic [WIDTH-1:0]     overrun
);

  localparam logic INV = (POLARITY == "LOW");

  logic [WIDTH-1:0]         sync1, sync2, data_q;
  logic [TIMEOUT_WIDTH-1:0] db_cnt [WIDTH];
  logic [7:0]               p_cnt  [WIDTH];
  logic [WIDTH-1:0]         pending, rise_lat;
  logic [WIDTH-1:0]         rise_det, fall_det, qual, take;
  logic [CH_W-1:0]          sel_ch;
  logic                     sel_any, load;

  // Synchroniser holds normalised (active-true) values so reset gives the inactive level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= data_in ^ {WIDTH{INV}};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      data_q   <= '0;
      for (int c = 0; c < WIDTH; c++) db_cnt[c] <= '0;
    end else begin
      data_q <= data_out;
      for (int c = 0; c < WIDTH; c++) begin
        if (sync2[c] == data_out[c]) begin
          db_cnt[c] <= '0;
        end else if (db_cnt[c] == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
          data_out[c] <= ~data_out[c];
          db_cnt[c]   <= '0;
        end else begin
          db_cnt[c] <= db_cnt[c] + TIMEOUT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    rise_det = data_out & ~data_q;
    fall_det = ~data_out & data_q;
    qual     = '0;
    busy     = '0;
    for (int c = 0; c < WIDTH; c++) begin
      qual[c] = (rise_det[c] & edge_mode[2*c]) | (fall_det[c] & edge_mode[2*c+1]);
      busy[c] = (p_cnt[c] != 8'd0);
    end
  end

  assign pulse_out = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < WIDTH; c++) p_cnt[c] <= 8'd0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        if (qual[c] && (p_cnt[c] == 8'd0 || retrigger[c])) p_cnt[c] <= 8'(PULSE_EXT);
        else if (p_cnt[c] != 8'd0)                          p_cnt[c] <= p_cnt[c] - 8'd1;
      end
    end
  end

  // Descending scan leaves the lowest pending index in sel_ch.
  always_comb begin
    sel_ch  = '0;
    sel_any = |pending;
    for (int c = WIDTH - 1; c >= 0; c--) begin
      if (pending[c]) sel_ch = CH_W'(c);
    end
    load = sel_any && (!evt_valid || evt_ready);
    take = load ? (WIDTH'(1) << sel_ch) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      rise_lat  <= '0;
      overrun   <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_ch    <= sel_ch;
        evt_rise  <= rise_lat[sel_ch];
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      // A new edge wins over both the pending clear and the overrun clear.
      pending  <= (pending & ~take) | qual;
      rise_lat <= (rise_lat & ~qual) | (rise_det & qual);
      overrun  <= (overrun & ~ovr_clear) | (qual & pending & ~take);
    end
  end

endmodule

// File: tb/tb_debounce_edge_events.sv
// tb/tb_debounce_edge_events.sv - bench for debounce_edge_events
// Two instances (TIMEOUT 8 and 2) share stimulus and are checked each cycle against a window/time-based model.
module tb_debounce_edge_events;
  localparam int P   = 6;
  localparam int TO0 = 8;
  localparam int TO1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [3:0]      data_in;
  logic [7:0]      edge_mode;
  logic [3:0]      retrigger, ovr_clear;
  logic            evt_ready;
  logic [1:0][3:0] d_out, p_out, b_out, ovr;
  logic [1:0]      ev_v, ev_r;
  logic [1:0][1:0] ev_ch;

  debounce_edge_events #(.WIDTH(4), .TIMEOUT(TO0), .TIMEOUT_WIDTH(16), .POLARITY("LOW"), .PULSE_EXT(P)) u0 (
    .clk(clk), .reset(reset), .data_in(data_in), .edge_mode(edge_mode), .retrigger(retrigger),
    .ovr_clear(ovr_clear), .evt_ready(evt_ready), .data_out(d_out[0]), .pulse_out(p_out[0]),
    .busy(b_out[0]), .evt_valid(ev_v[0]), .evt_ch(ev_ch[0]), .evt_rise(ev_r[0]), .overrun(ovr[0]));

  debounce_edge_events #(.WIDTH(4), .TIMEOUT(TO1), .TIMEOUT_WIDTH(4), .POLARITY("LOW"), .PULSE_EXT(P)) u1 (
    .clk(clk), .reset(reset), .data_in(data_in), .edge_mode(edge_mode), .retrigger(retrigger),
    .ovr_clear(ovr_clear), .evt_ready(evt_ready), .data_out(d_out[1]), .pulse_out(p_out[1]),
    .busy(b_out[1]), .evt_valid(ev_v[1]), .evt_ch(ev_ch[1]), .evt_rise(ev_r[1]), .overrun(ovr[1]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int ncyc   = 0;

  logic [3:0]  m_d1, m_d2;
  logic [15:0] m_sh [2][4];
  logic [3:0]  m_dout [2], m_dprev [2], m_pend [2], m_lat [2], m_ovr [2];
  int          m_pstart [2][4];
  bit          m_pval [2][4];
  logic        m_v [2], m_rise [2];
  logic [1:0]  m_ch [2];

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL u%0d %s got %0h exp %0h (t=%0t)", i, nm, got, exp, $time);
    end
  endtask

  function automatic bit pulse_on(int i, int c, int n);
    return m_pval[i][c] && (n - m_pstart[i][c] < P);
  endfunction

  task automatic model_step();
    ncyc++;
    for (int i = 0; i < 2; i++) begin
      logic [3:0]  q, re, fe;
      logic [15:0] mask;
      int          lo, tout;
      tout = (i == 0) ? TO0 : TO1;
      if (reset) begin
        m_dout[i] = 0; m_dprev[i] = 0; m_pend[i] = 0; m_lat[i] = 0; m_ovr[i] = 0;
        m_v[i] = 0; m_rise[i] = 0; m_ch[i] = 0;
        for (int c = 0; c < 4; c++) begin m_sh[i][c] = 0; m_pval[i][c] = 0; m_pstart[i][c] = 0; end
      end else begin
        re = m_dout[i] & ~m_dprev[i];
        fe = ~m_dout[i] & m_dprev[i];
        for (int c = 0; c < 4; c++) begin
          q[c] = (re[c] & edge_mode[2*c]) | (fe[c] & edge_mode[2*c+1]);
          if (q[c] && (!pulse_on(i, c, ncyc - 1) || retrigger[c])) begin
            m_pstart[i][c] = ncyc;
            m_pval[i][c]   = 1'b1;
          end
        end
        if (!m_v[i] || evt_ready) begin
          lo = -1;
          for (int c = 3; c >= 0; c--) if (m_pend[i][c]) lo = c;
          if (lo >= 0) begin
            m_v[i] = 1'b1; m_ch[i] = 2'(lo); m_rise[i] = m_lat[i][lo]; m_pend[i][lo] = 1'b0;
          end else begin
            m_v[i] = 1'b0;
          end
        end
        m_ovr[i] = m_ovr[i] & ~ovr_clear;
        for (int c = 0; c < 4; c++) begin
          if (q[c]) begin
            if (m_pend[i][c]) m_ovr[i][c] = 1'b1;
            m_pend[i][c] = 1'b1;
            m_lat[i][c]  = re[c];
          end
        end
        m_dprev[i] = m_dout[i];
        // Level flips once the last tout synchronised samples all disagree with it.
        mask = 16'((32'd1 << tout) - 1);
        for (int c = 0; c < 4; c++) begin
          m_sh[i][c] = {m_sh[i][c][14:0], m_d2[c]};
          if ((m_sh[i][c] & mask) == (m_dout[i][c] ? 16'd0 : mask)) m_dout[i][c] = ~m_dout[i][c];
        end
      end
    end
    if (reset) begin m_d1 = 0; m_d2 = 0; end
    else begin m_d2 = m_d1; m_d1 = ~data_in; end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] pe;
      for (int c = 0; c < 4; c++) pe[c] = pulse_on(i, c, ncyc);
      chk("data_out",  i, 32'(d_out[i]), 32'(m_dout[i]));
      chk("pulse_out", i, 32'(p_out[i]), 32'(pe));
      chk("busy",      i, 32'(b_out[i]), 32'(pe));
      chk("evt_valid", i, 32'(ev_v[i]),  32'(m_v[i]));
      chk("overrun",   i, 32'(ovr[i]),   32'(m_ovr[i]));
      if (m_v[i]) begin
        chk("evt_ch",   i, 32'(ev_ch[i]), 32'(m_ch[i]));
        chk("evt_rise", i, 32'(ev_r[i]),  32'(m_rise[i]));
      end
    end
  endtask

  always @(posedge clk) model_step();
  always @(posedge clk) begin
    #1;
    if (chk_en) compare();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int evc, hi;
    bit seen;
    logic [1:0] e_ch [4];
    logic       e_r  [4];
    reset = 1'b1; data_in = 4'hF; edge_mode = 8'hFF; retrigger = 4'h0; ovr_clear = 4'h0; evt_ready = 1'b1;
    repeat (4) step();
    reset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_data_out", i, 32'(d_out[i]), 0);
      chk("rst_pulse",    i, 32'(p_out[i]), 0);
      chk("rst_evt",      i, 32'({ev_v[i], ev_ch[i], ev_r[i], ovr[i]}), 0);
    end
    evc = 0;
    repeat (100) begin step(); if (ev_v != 2'b00) evc++; end
    chk("rst_quiet", 0, evc, 0);

    // Bounce on ch0: glitch sampled at edge 5, stable from edge 6.
    data_in[0] = 1'b0; step();
    repeat (4) step();
    data_in[0] = 1'b1; step();
    data_in[0] = 1'b0;
    repeat (9) step();
    chk("bounce_d14", 0, 32'(d_out[0][0]), 0);
    step(); chk("bounce_d15", 0, 32'(d_out[0][0]), 1);
    step(); chk("bounce_p16", 0, 32'(p_out[0][0]), 1); chk("bounce_v16", 0, 32'(ev_v[0]), 0);
    step(); chk("bounce_v17", 0, 32'({ev_v[0], ev_ch[0], ev_r[0]}), 32'b1001);
    repeat (4) step(); chk("bounce_p21", 0, 32'(p_out[0][0]), 1);
    step(); chk("bounce_p22", 0, 32'(p_out[0][0]), 0);

    // Both-edge mode on ch1: press, release 40 cycles later.
    evc = 0;
    data_in[1] = 1'b0;
    for (int n = 0; n < 70; n++) begin
      if (n == 40) data_in[1] = 1'b1;
      step();
      if (ev_v[0]) begin
        if (evc < 4) begin e_ch[evc] = ev_ch[0]; e_r[evc] = ev_r[0]; end
        evc++;
      end
    end
    chk("both_count", 0, evc, 2);
    if (evc >= 2) begin
      chk("both_ev0", 0, 32'({e_ch[0], e_r[0]}), 32'b011);
      chk("both_ev1", 0, 32'({e_ch[1], e_r[1]}), 32'b010);
    end

    // Retrigger on u1 ch2: release 3 cycles after press.
    for (int r = 1; r >= 0; r--) begin
      retrigger[2] = 1'(r);
      data_in[2] = 1'b0;
      repeat (3) step();
      data_in[2] = 1'b1;
      hi = 0;
      repeat (20) begin step(); if (p_out[1][2]) hi++; end
      chk(r ? "retrig_on_len" : "retrig_off_len", 1, hi, r ? 9 : 6);
    end
    retrigger = 4'h0;

    // Backpressure and overrun on u0: ch0 and ch3 together, then two more ch3 edges.
    evt_ready = 1'b0;
    data_in[0] = 1'b1; data_in[3] = 1'b0;
    repeat (14) step();
    data_in[3] = 1'b1;
    repeat (14) step();
    data_in[3] = 1'b0;
    repeat (14) step();
    chk("bp_held", 0, 32'({ev_v[0], ev_ch[0], ev_r[0]}), 32'b1000);
    chk("bp_overrun3", 0, 32'(ovr[0][3]), 1);
    evt_ready = 1'b1;
    step(); chk("bp_next", 0, 32'({ev_v[0], ev_ch[0], ev_r[0]}), 32'b1111);
    step(); chk("bp_drained", 0, 32'(ev_v[0]), 0);
    ovr_clear[3] = 1'b1; step(); ovr_clear = 4'h0;
    chk("bp_ovr_clear", 0, 32'(ovr[0][3]), 0);

    // Reset two cycles after u0 pulse_out[1] rises.
    data_in[1] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin step(); seen = p_out[0][1]; end
    chk("mid_pulse_seen", 0, 32'(seen), 1);
    step(); step();
    reset = 1'b1; data_in = 4'hF;
    step();
    chk("mid_rst_outs", 0, 32'({p_out[0], b_out[0], ev_v[0]}), 0);
    step();
    reset = 1'b0;
    evc = 0;
    repeat (30) begin step(); if (ev_v[0]) evc++; end
    chk("mid_rst_quiet", 0, evc, 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 15) == 0) data_in[c] = ~data_in[c];
      evt_ready = ($urandom_range(0, 3) != 0);
      ovr_clear = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      if (n % 200 == 0) begin edge_mode = 8'($urandom); retrigger = 4'($urandom); end
      reset = (n == 1500);
      step();
    end
    reset = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce_edge_events.md
# debounce_edge_events

Multi-channel debouncer with per-channel edge detection, pulse stretching and a queued edge-event stream. It is the generalised successor of the button-debounce and reset-pulse logic in the FPGA fabric. Each channel combines the debounce stage with the edge-to-pulse stage, adds a runtime-selectable edge mode and a retrigger policy, and reports every qualifying edge through a valid/ready event port for a CSR or interrupt block.

## Interface
- WIDTH, 4: number of channels, 1..16.
- TIMEOUT, 50000: number of consecutive stable cycles required to accept a level change; ≥1.
- TIMEOUT_WIDTH, 16: debounce counter width; 2^TIMEOUT_WIDTH > TIMEOUT.
- POLARITY, "LOW": "LOW" means data_in active-low; "HIGH" means active-high.
- PULSE_EXT, 6: pulse_out length in cycles; 1..255.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  raw asynchronous inputs.
- edge_mode  in  2*WIDTH  per channel, bits [2c+1:2c]: 00 none, 01 rise, 10 fall, 11 both.
- retrigger  in  WIDTH  1 = a qualifying edge while busy restarts the pulse; 0 = it is ignored for the pulse.
- ovr_clear  in  WIDTH  clears overrun[c].
- evt_ready  in  1  event consumer ready.
- data_out  out  WIDTH  debounced level, active-true.
- pulse_out  out  WIDTH  stretched edge pulse.
- busy  out  WIDTH  pulse counter non-zero.
- evt_valid  out  1  event available.
- evt_ch  out  max(1,$clog2(WIDTH))  channel of the event.
- evt_rise  out  1  1 = rising edge of data_out, 0 = falling edge.
- overrun  out  WIDTH  sticky flag: an edge arrived while that channel's event was still pending.

## Operation
- Synchroniser: two flops per channel. The value is normalised to active-true (inverted when POLARITY="LOW").
- Debounce, per channel:
  - Counter increments on every cycle where the synchronised value ≠ data_out.
  - Any cycle where they are equal clears the counter.
  - When the counter = TIMEOUT-1 and they still differ, data_out toggles and the counter clears.
- Edge detect: a registered copy of data_out gives rise (0→1) or fall (1→0). An edge qualifies only if edge_mode[c] enables that direction. edge_mode is sampled on the detect cycle; a change never alters a pulse already in progress.
- Pulse counter, per channel:
  - Loads PULSE_EXT on a qualifying edge when idle, or when busy with retrigger[c]=1.
  - Otherwise it decrements to 0.
  - pulse_out = busy = (count ≠ 0).
- Event queue:
  - pending[c] and rise_lat[c] are set on a qualifying edge.
  - A single output register (evt_valid, evt_ch, evt_rise) loads the lowest-index pending channel when it is empty or being accepted (evt_valid & evt_ready), clearing that pending bit.
  - The output holds stable while evt_valid & !evt_ready.
- Overrun: a qualifying edge on channel c with pending[c] already set sets overrun[c] and overwrites rise_lat[c]. Only one event stays pending per channel.
- Simultaneous events on the same channel and cycle:
  - Edge and pending-clear: the set wins, and no overrun is flagged.
  - ovr_clear and a new overrun: the set wins.
  - Edge while the event for c sits in the output register: the edge queues in pending[c], with no overrun.
- Reset:
  - Synchroniser flops load the inactive level, so no edge is produced on release.
  - Debounce and pulse counters are 0.
  - data_out, pulse_out, busy, pending, overrun and evt_valid are 0. evt_ch and evt_rise are 0.
  - Reset mid-pulse or mid-handshake drops all state with no trailing pulse or event.

## Timing
- Let edge 0 be the first clk edge at which the new data_in level is sampled, held stable thereafter.
- data_out takes the new value at edge TIMEOUT+1.
- pulse_out, busy and pending rise at edge TIMEOUT+2. pulse_out stays high for exactly PULSE_EXT cycles unless retriggered.
- evt_valid rises at edge TIMEOUT+3 if the output register is empty.
- Throughput is one event per cycle with evt_ready held high. Accept and reload happen on the same edge.
- A glitch of any length < TIMEOUT cycles (as seen after the synchroniser) produces no data_out change.

## Test plan
- Reset: hold reset 4 cycles with data_in=4'hF (LOW polarity), release → all outputs 0, and no evt_valid for 100 cycles.
- Bounce (TIMEOUT=8): drive data_in[0]=0 at edge 0, then 1 for one cycle at edge 5, then 0 from edge 6 → data_out[0]=1 at edge 15; pulse_out[0] high edges 16–21; evt_valid at edge 17 with evt_ch=0, evt_rise=1.
- Both-edge mode (edge_mode ch1=11): press, then release 40 cycles later → two events on ch1, evt_rise=1 then evt_rise=0, in order.
- Retrigger (TIMEOUT=2, both mode, ch2): release 3 cycles after press → retrigger=1 gives pulse_out[2] high for 9 continuous cycles; retrigger=0 gives 6 cycles.
- Backpressure/overrun: evt_ready=0; edges on ch0 and ch3 in the same cycle, then 2 more edges on ch3 → evt_ch=0 held stable and overrun[3]=1. Raise evt_ready → ch0 then ch3, with evt_rise equal to the latest ch3 edge. ovr_clear[3] pulse → overrun[3]=0.
- Reset mid-pulse: assert reset 2 cycles after pulse_out[1] rises → the next cycle shows pulse_out, evt_valid and pending all 0, with no event after release.
